// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_sampler
// Brief    : Samples an async 4-bit ripple counter, filters ripple glitches,
//            extends it into a wide total and reports per-window event counts.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_count_sampler #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int WINDOW        = 256,
    parameter int EXT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       ripple_q,
    output logic [EXT_W-1:0] total,
    output logic             stable,
    output logic [EXT_W-1:0] meas_data,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun
);

    localparam int c_STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int c_WIN_W  = $clog2(WINDOW);

    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE_CYCLES);
    localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(WINDOW - 1);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_MEASURE = 1'b1;

    logic [3:0]          w_sync_q;
    logic [3:0]          r_cand;
    logic [3:0]          r_accepted;
    logic [c_STAB_W-1:0] r_stab_cnt;
    logic                w_accept;
    logic [3:0]          w_delta;
    logic [EXT_W-1:0]    w_delta_ext;

    logic [0:0]          r_state;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [EXT_W-1:0]    r_win_acc;
    logic [EXT_W-1:0]    w_win_add;
    logic [EXT_W:0]      w_win_sum;
    logic [EXT_W-1:0]    w_win_next;
    logic                w_done;
    logic                w_hs;

    genvar gb;
    generate
        for (gb = 0; gb < 4; gb++) begin : g_sync_bit
            logic [SYNC_STAGES-1:0] r_chain;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], ripple_q[gb]};
                end
            end

            assign w_sync_q[gb] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    // An accept needs a candidate that has survived STABLE_CYCLES samples;
    // a one-cycle ripple transient restarts the run and is never accepted.
    assign w_accept    = (r_stab_cnt == c_STAB_MAX) && (r_cand != r_accepted);
    assign w_delta     = r_cand - r_accepted;
    assign w_delta_ext = {{(EXT_W-4){1'b0}}, w_delta};
    assign stable      = (w_sync_q == r_accepted);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand     <= 4'h0;
            r_stab_cnt <= '0;
            r_accepted <= 4'h0;
        end else begin
            if (w_sync_q != r_cand) begin
                r_cand     <= w_sync_q;
                r_stab_cnt <= c_STAB_W'(1);
            end else if (r_stab_cnt != c_STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + c_STAB_W'(1);
            end
            if (w_accept) begin
                r_accepted <= r_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total <= '0;
        end else if (en && w_accept) begin
            total <= total + w_delta_ext;
        end
    end

    assign w_win_add  = w_accept ? w_delta_ext : '0;
    assign w_win_sum  = {1'b0, r_win_acc} + {1'b0, w_win_add};
    assign w_win_next = w_win_sum[EXT_W] ? '1 : w_win_sum[EXT_W-1:0];
    assign w_done     = (r_state == c_MEASURE) && en && (r_win_cnt == c_WIN_LAST);
    assign w_hs       = meas_valid && meas_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_win_cnt <= '0;
            r_win_acc <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_win_cnt <= '0;
                    r_win_acc <= '0;
                    if (en) begin
                        r_state <= c_MEASURE;
                    end
                end
                c_MEASURE: begin
                    if (!en) begin
                        r_state   <= c_IDLE;
                        r_win_cnt <= '0;
                        r_win_acc <= '0;
                    end else if (r_win_cnt == c_WIN_LAST) begin
                        r_win_cnt <= '0;
                        r_win_acc <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                        r_win_acc <= w_win_next;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // One-deep result slot: a completion may reuse the slot only if it is
    // empty or being drained in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_data  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_done) begin
            if (!meas_valid || w_hs) begin
                meas_data  <= w_win_next;
                meas_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (w_hs) begin
            meas_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_count_sampler
// Brief    : Scenario and randomized bench for ripple_count_sampler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_count_sampler;

    localparam int SYNC = 2;
    localparam int STAB = 2;
    localparam int WIN  = 16;
    localparam int EW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    ripple_q;
    logic [EW-1:0] total;
    logic          stable;
    logic [EW-1:0] meas_data;
    logic          meas_valid;
    logic          meas_ready;
    logic          overrun;

    int checks = 0;
    int passed = 0;
    int edge_cnt = 0;

    // Reference model state
    logic [3:0] m_dq[$];
    logic [3:0] m_seen[$];
    logic [3:0] m_acc;
    int         m_total, m_pos, m_wsum, m_data;
    bit         m_meas, m_valid, m_ovr;

    ripple_count_sampler #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STAB),
        .WINDOW       (WIN),
        .EXT_W        (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ripple_q  (ripple_q),
        .total     (total),
        .stable    (stable),
        .meas_data (meas_data),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the behavioural rules to the model.
    task automatic step();
        logic [3:0] consumed;
        bit         agree, hs, done;
        int         delta, wres;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            m_dq = {};
            repeat (SYNC) m_dq.push_back(4'h0);
            m_seen = {};
            m_acc = 4'h0; m_total = 0; m_pos = 0; m_wsum = 0; m_data = 0;
            m_meas = 0; m_valid = 0; m_ovr = 0;
        end else begin
            delta = 0;
            agree = (m_seen.size() == STAB);
            foreach (m_seen[i]) if (m_seen[i] != m_seen[0]) agree = 0;
            if (agree && m_seen[0] != m_acc) begin
                delta = int'(m_seen[0]) - int'(m_acc);
                if (delta < 0) delta += 16;
                m_acc = m_seen[0];
            end
            consumed = m_dq.pop_front();
            m_dq.push_back(ripple_q);
            m_seen.push_back(consumed);
            if (m_seen.size() > STAB) void'(m_seen.pop_front());

            if (en) m_total = (m_total + delta) % (1 << EW);

            hs = m_valid && meas_ready;
            done = 0;
            wres = 0;
            if (!m_meas) begin
                m_pos = 0; m_wsum = 0;
                if (en) m_meas = 1;
            end else if (!en) begin
                m_meas = 0; m_pos = 0; m_wsum = 0;
            end else begin
                m_wsum = m_wsum + delta;
                if (m_wsum > (1 << EW) - 1) m_wsum = (1 << EW) - 1;
                if (m_pos == WIN - 1) begin
                    done = 1; wres = m_wsum; m_wsum = 0; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (done) begin
                if (!m_valid || hs) begin
                    m_data = wres; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (hs) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; meas_ready = 1'b0; ripple_q = 4'h0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        en = 1'b1; ripple_q = 4'h5;
        repeat (8) step();
        rst = 1'b1;
        step();
        checks++; if (total !== '0) $display("FAIL rst_total got %0d exp 0", total); else passed++;
        checks++; if (meas_data !== '0) $display("FAIL rst_data got %0d exp 0", meas_data); else passed++;
        checks++; if (meas_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", meas_valid); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else passed++;
        checks++; if (stable !== 1'b1) $display("FAIL rst_stable got %b exp 1", stable); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_count_steps();
        int present_edge, change_edge;
        logic [EW-1:0] prev;
        do_reset();
        en = 1'b1; meas_ready = 1'b1; ripple_q = 4'h0;
        repeat (8) step();
        for (int v = 1; v <= 17; v++) begin
            ripple_q = 4'(v % 16);
            present_edge = edge_cnt + 1;
            change_edge = -100;
            for (int c = 0; c < 8; c++) begin
                prev = total;
                step();
                if (total !== prev) change_edge = edge_cnt;
                checks++;
                if (total !== EW'(m_total)) $display("FAIL step_total got %0d exp %0d", total, m_total);
                else passed++;
            end
            checks++;
            if (change_edge - present_edge != SYNC + STAB)
                $display("FAIL step_latency value %0d got %0d exp %0d", v, change_edge - present_edge, SYNC + STAB);
            else passed++;
        end
        checks++; if (total !== EW'(17)) $display("FAIL step_final got %0d exp 17", total); else passed++;
    endtask

    task automatic test_glitch();
        int low_cnt, changes;
        logic [EW-1:0] prev;
        do_reset();
        en = 1'b1; meas_ready = 1'b1; ripple_q = 4'h7;
        repeat (8) step();
        checks++; if (total !== EW'(7)) $display("FAIL glitch_pre got %0d exp 7", total); else passed++;
        low_cnt = 0; changes = 0;
        for (int c = 0; c < 9; c++) begin
            ripple_q = (c == 0) ? 4'h6 : 4'h8;
            prev = total;
            step();
            if (total !== prev) changes++;
            if (stable === 1'b0) low_cnt++;
            checks++;
            if (stable !== (m_dq[0] == m_acc)) $display("FAIL glitch_stable got %b exp %b", stable, m_dq[0] == m_acc);
            else passed++;
        end
        checks++; if (changes != 1) $display("FAIL glitch_accepts got %0d exp 1", changes); else passed++;
        checks++; if (total !== EW'(8)) $display("FAIL glitch_total got %0d exp 8", total); else passed++;
        checks++; if (low_cnt == 0) $display("FAIL glitch_stable_low got %0d exp >0", low_cnt); else passed++;
    endtask

    task automatic test_window();
        int last_pulse, pulses;
        logic [3:0] cur;
        do_reset();
        en = 1'b1; meas_ready = 1'b1; cur = 4'h0;
        last_pulse = -1; pulses = 0;
        for (int i = 0; i < 96; i++) begin
            if (i % 4 == 0) cur = cur + 4'h1;
            ripple_q = cur;
            step();
            checks++;
            if (meas_valid !== m_valid || (m_valid && meas_data !== EW'(m_data)))
                $display("FAIL win_model valid %b/%b data %0d/%0d", meas_valid, m_valid, meas_data, m_data);
            else passed++;
            if (meas_valid === 1'b1) begin
                pulses++;
                if (last_pulse >= 0) begin
                    checks++;
                    if (edge_cnt - last_pulse != WIN) $display("FAIL win_spacing got %0d exp %0d", edge_cnt - last_pulse, WIN);
                    else passed++;
                    checks++;
                    if (meas_data !== EW'(4)) $display("FAIL win_data got %0d exp 4", meas_data);
                    else passed++;
                end
                last_pulse = edge_cnt;
            end
        end
        checks++; if (pulses != 5) $display("FAIL win_pulses got %0d exp 5", pulses); else passed++;
    endtask

    task automatic test_overrun();
        int first;
        logic [3:0] cur;
        do_reset();
        en = 1'b1; meas_ready = 1'b0; cur = 4'h0; first = -1;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) cur = cur + 4'h1;
            ripple_q = cur;
            step();
            if (m_valid && first < 0) first = m_data;
            if (i == 20) begin
                checks++; if (overrun !== 1'b0) $display("FAIL ovr_early got %b exp 0", overrun); else passed++;
            end
        end
        checks++; if (meas_valid !== 1'b1) $display("FAIL ovr_valid got %b exp 1", meas_valid); else passed++;
        checks++; if (meas_data !== EW'(first)) $display("FAIL ovr_held got %0d exp %0d", meas_data, first); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b exp 1", overrun); else passed++;
        meas_ready = 1'b1;
        step();
        checks++; if (meas_valid !== 1'b0) $display("FAIL ovr_drain got %b exp 0", meas_valid); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun); else passed++;
    endtask

    task automatic test_en_drop();
        int pulses, pdata;
        do_reset();
        en = 1'b1; meas_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            ripple_q = (i < 3) ? 4'h1 : (i < 6) ? 4'h2 : 4'h3;
            step();
        end
        checks++; if (total !== EW'(3)) $display("FAIL endrop_pre got %0d exp 3", total); else passed++;
        en = 1'b0; ripple_q = 4'h5;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (meas_valid !== 1'b0) $display("FAIL endrop_partial got %b exp 0", meas_valid); else passed++;
        end
        checks++; if (total !== EW'(3)) $display("FAIL endrop_total_off got %0d exp 3", total); else passed++;
        en = 1'b1; pulses = 0; pdata = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (meas_valid === 1'b1) begin pulses++; pdata = int'(meas_data); end
        end
        checks++; if (pulses != 1) $display("FAIL endrop_pulses got %0d exp 1", pulses); else passed++;
        checks++; if (pdata != 0) $display("FAIL endrop_fresh got %0d exp 0", pdata); else passed++;
        checks++; if (total !== EW'(3)) $display("FAIL endrop_total got %0d exp 3", total); else passed++;
    endtask

    task automatic test_rst_handshake();
        logic [3:0] cur;
        do_reset();
        en = 1'b1; meas_ready = 1'b0; cur = 4'h0;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) cur = cur + 4'h1;
            ripple_q = cur;
            step();
        end
        checks++; if (meas_valid !== 1'b1) $display("FAIL rsths_pre got %b exp 1", meas_valid); else passed++;
        meas_ready = 1'b1; rst = 1'b1;
        step();
        checks++; if (total !== '0) $display("FAIL rsths_total got %0d exp 0", total); else passed++;
        checks++; if (meas_data !== '0) $display("FAIL rsths_data got %0d exp 0", meas_data); else passed++;
        checks++; if (meas_valid !== 1'b0) $display("FAIL rsths_valid got %b exp 0", meas_valid); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL rsths_overrun got %b exp 0", overrun); else passed++;
        checks++; if (stable !== 1'b1) $display("FAIL rsths_stable got %b exp 1", stable); else passed++;
        rst = 1'b0; en = 1'b0;
        step();
        checks++; if (meas_valid !== 1'b0) $display("FAIL rsths_after got %b exp 0", meas_valid); else passed++;
    endtask

    task automatic test_random();
        int hold;
        logic [3:0] cur;
        do_reset();
        en = 1'b1; cur = 4'h0; hold = 0;
        for (int i = 0; i < 1200; i++) begin
            if (hold == 0) begin
                cur  = cur + 4'($urandom_range(0, 4));
                hold = $urandom_range(1, 6);
            end
            hold--;
            ripple_q = ($urandom_range(0, 15) == 0) ? 4'($urandom) : cur;
            if ($urandom_range(0, 63) == 0) en = ~en;
            meas_ready = 1'($urandom_range(0, 1));
            step();
            checks++; if (total !== EW'(m_total)) $display("FAIL rnd_total got %0d exp %0d", total, m_total); else passed++;
            checks++; if (stable !== (m_dq[0] == m_acc)) $display("FAIL rnd_stable got %b exp %b", stable, m_dq[0] == m_acc); else passed++;
            checks++; if (meas_valid !== m_valid) $display("FAIL rnd_valid got %b exp %b", meas_valid, m_valid); else passed++;
            checks++; if (meas_data !== EW'(m_data)) $display("FAIL rnd_data got %0d exp %0d", meas_data, m_data); else passed++;
            checks++; if (overrun !== m_ovr) $display("FAIL rnd_overrun got %b exp %b", overrun, m_ovr); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; meas_ready = 1'b0; ripple_q = 4'h0;
        test_reset();
        test_count_steps();
        test_glitch();
        test_window();
        test_overrun();
        test_en_drop();
        test_rst_handshake();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter output.
- Brings the counter value into the `clk` domain with a synchronizer and rejects mid-ripple glitch codes with a stability filter.
- Extends the count modulo 16 into a wide running total.
- Publishes per-window event counts to a consumer over a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2, flops in the per-bit synchronizer chain (min 2).
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before a value is accepted (min 1).
- WINDOW, 256, measurement window length in `clk` cycles (min 2).
- EXT_W, 16, width of the running total and the window result (min 5).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  measurement enable.
- ripple_q  in  4  ripple counter output; asynchronous to `clk`, may show transient codes.
- total  out  EXT_W  running extended count of accepted increments.
- stable  out  1  high when the current synchronized sample equals the accepted value.
- meas_data  out  EXT_W  event count of the last completed window.
- meas_valid  out  1  meas_data holds an unconsumed result.
- meas_ready  in  1  consumer accepts the result when meas_valid and meas_ready are both high.
- overrun  out  1  sticky: a window result was dropped.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Clears synchronizer flops, candidate, stability counter, accepted value (4'h0), total, window counter and window accumulator.
  - Outputs after reset: total=0, meas_data=0, meas_valid=0, overrun=0, stable=1.
  - State goes to IDLE.
  - rst overrides every other event in the same cycle, including a completing handshake.
- Synchronizer: each ripple_q bit passes through SYNC_STAGES flops; sync_q is the last stage.
- Stability filter:
  - If sync_q differs from candidate: candidate<=sync_q, stab_cnt<=1.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - When stab_cnt reaches STABLE_CYCLES and candidate differs from accepted, an accept occurs: delta=(candidate-accepted) mod 16, then accepted<=candidate.
  - The filter and the accepted value run regardless of en, so re-enabling never produces a bogus delta.
- Latency: a ripple_q value held steady is reflected in total exactly SYNC_STAGES+STABLE_CYCLES clock edges after the first edge that samples it.
- Aliasing: the counter must advance fewer than 16 counts between accepts. Larger advances alias; this is not detected.
- Running total:
  - When en=1 and an accept occurs, total<=total+delta, wrapping modulo 2^EXT_W.
  - Deltas with en=0 are discarded.
- FSM:
  - IDLE: window counter held at 0, window accumulator held at 0. en=1 moves to MEASURE on the next edge.
  - MEASURE: window counter counts 0..WINDOW-1; accepted deltas add into the window accumulator, saturating at all-ones.
  - At window counter = WINDOW-1, the window completes. The delta accepted in that same cycle belongs to the completing window.
  - On completion: the accumulator restarts at 0, the counter wraps to 0, and the FSM stays in MEASURE.
  - en=0 in MEASURE: return to IDLE; the partial window is discarded and produces no result.
- Result handshake (one-deep):
  - On window completion, if meas_valid=0 or a handshake completes in that same cycle: meas_data<=accumulator, meas_valid<=1.
  - Otherwise the new result is dropped, overrun<=1, and meas_data keeps the older result.
  - A handshake with no window completing clears meas_valid; meas_data holds its value.
  - meas_data never changes while meas_valid=1 and meas_ready=0.
  - en=0 does not clear a pending meas_valid.
  - overrun clears only on rst.

Test Plan:
- rst, en=1, ripple_q stepped 0,1,...,15,0,1 with each value held 8 cycles -> total=17, and each increment lands SYNC_STAGES+STABLE_CYCLES edges after the value is presented.
- ripple_q 4'h7 for 8 cycles, glitch 4'h6 for 1 cycle, then 4'h8 held -> exactly one accept with delta=1 (the 6 is never accepted), stable low during the transition.
- WINDOW=16, meas_ready=1, ripple_q incremented once every 4 cycles -> meas_valid pulses one cycle every 16 cycles with meas_data=4.
- meas_ready=0 across two window completions -> first result held in meas_data, overrun=1 after the second completion; then meas_ready=1 -> meas_valid drops, overrun stays 1.
- en dropped mid-window after 3 increments, ripple_q moved +2, en raised -> no result from the partial window, total unchanged by the +2, next full window counts from 0.
- rst asserted while meas_valid=1 and meas_ready=1 in the same cycle -> all outputs at reset values on the next edge, no handshake counted.
